// File: rtl/fsk_bist_monitor_pkg.sv
// Shared definitions for the FSK modem self-test monitor.
//   state_e    : FSM state encoding (Idle=0, Run=1, Drain=2, Done=3)
//   within_tol : |c - target| <= tol on unsigned operands
package fsk_bist_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic within_tol(input int unsigned c, input int unsigned target,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (c > target) ? (c - target) : (target - c);
    return diff <= tol;
  endfunction

endpackage

// File: rtl/fsk_bist_monitor_prbs_gen.sv
// Fibonacci PRBS generator for the self-test monitor.
// Ports:
//   i_clk        : clock, rising edge
//   i_reset_n    : asynchronous active-low reset (loads the seed)
//   i_load       : reload the seed
//   i_shift      : advance one step
//   o_next_msb   : MSB the register will hold after the next shift
module fsk_bist_monitor_prbs_gen #(
  parameter int unsigned       LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = 7'h60,
  parameter logic [LFSR_W-1:0] SEED   = 7'h01
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_load,
  input  logic i_shift,
  output logic o_next_msb
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SeedEff =
      (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;

  assign w_lfsr_next = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  assign o_next_msb  = w_lfsr_next[LFSR_W-1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lfsr <= SeedEff;
    end else if (i_load) begin
      r_lfsr <= SeedEff;
    end else if (i_shift) begin
      r_lfsr <= w_lfsr_next;
    end
  end

endmodule

// File: rtl/fsk_bist_monitor.sv
// Self-test monitor for the FSK modem. Drives PRBS bits on o_tx_data at a fixed
// bit rate, counts synchronised rising edges of i_fsk_out per bit window,
// classifies each window as 0/1/invalid and compares it with the bit sent
// LAT_BITS windows earlier.
// Ports:
//   i_tx_clk   : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_start    : one-cycle run request, honoured in Idle/Done only
//   i_fsk_out  : modem output, may be asynchronous
//   o_tx_data  : serial bit to the modem
//   o_bit_stb  : first cycle of each transmitted bit
//   o_busy     : Run or Drain
//   o_done     : Done state
//   o_pass     : Done with zero errors
//   o_err_cnt  : mismatched/invalid windows, saturating
module fsk_bist_monitor
  import fsk_bist_monitor_pkg::*;
#(
  parameter int unsigned       LFSR_W     = 7,
  parameter logic [LFSR_W-1:0] TAPS       = 7'h60,
  parameter logic [LFSR_W-1:0] SEED       = 7'h01,
  parameter int unsigned       BIT_CYCLES = 16,
  parameter int unsigned       NUM_BITS   = 20,
  parameter int unsigned       LAT_BITS   = 1,
  parameter int unsigned       F0_EDGES   = 2,
  parameter int unsigned       F1_EDGES   = 4,
  parameter int unsigned       TOL        = 0,
  parameter int unsigned       CNT_W      = 8
) (
  input  logic             i_tx_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_fsk_out,
  output logic             o_tx_data,
  output logic             o_bit_stb,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned EDGE_W  = $clog2(BIT_CYCLES) + 1;
  localparam int unsigned CYC_W   = $clog2(BIT_CYCLES);
  localparam int unsigned NUM_WIN = NUM_BITS + LAT_BITS;
  localparam int unsigned WIN_W   = $clog2(NUM_WIN + 1);
  localparam logic [LFSR_W-1:0] SeedEff =
      (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  state_e             r_state;
  logic [CYC_W-1:0]   r_cyc;
  logic [WIN_W-1:0]   r_win;
  logic [EDGE_W-1:0]  r_edge_cnt;
  logic               r_sync1, r_sync2, r_sync3;
  logic [LAT_BITS:0]  r_dly;
  logic               r_tx_data, r_bit_stb, r_busy, r_done, r_pass;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_active, w_start_ok, w_win_end, w_last_bit, w_last_win;
  logic               w_edge, w_is1, w_is0, w_checked, w_err;
  logic               w_shift, w_next_bit, w_lfsr_msb;
  logic [EDGE_W-1:0]  w_edge_total;
  logic [CNT_W-1:0]   w_err_next;
  logic [LAT_BITS:0]  w_dly_shift, w_dly_load;

  fsk_bist_monitor_prbs_gen #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_prbs (
    .i_clk      (i_tx_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_start_ok),
    .i_shift    (w_shift),
    .o_next_msb (w_lfsr_msb)
  );

  assign w_active   = (r_state == StRun) || (r_state == StDrain);
  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_win_end  = w_active && (r_cyc == CYC_W'(BIT_CYCLES - 1));
  assign w_last_bit = (r_win == WIN_W'(NUM_BITS - 1));
  assign w_last_win = (r_win == WIN_W'(NUM_WIN - 1));

  // Edge seen in this cycle belongs to the window holding this cycle.
  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_edge_total = r_edge_cnt + {{(EDGE_W-1){1'b0}}, w_edge};

  // F1 is tested first so an overlapping tolerance band resolves to 1.
  assign w_is1 = within_tol(32'(w_edge_total), F1_EDGES, TOL);
  assign w_is0 = !w_is1 && within_tol(32'(w_edge_total), F0_EDGES, TOL);

  assign w_checked  = (r_win >= WIN_W'(LAT_BITS));
  assign w_err      = w_win_end && w_checked &&
                      (!(w_is1 || w_is0) || (w_is1 != r_dly[LAT_BITS]));
  assign w_err_next = (w_err && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;

  // Bit for the next window: next PRBS bit while still sending, else 0.
  assign w_shift    = w_win_end && (r_state == StRun) && !w_last_bit;
  assign w_next_bit = w_shift ? w_lfsr_msb : 1'b0;

  // r_dly[j] holds the bit sent j windows ago; r_dly[0] is the current bit.
  always_comb begin
    w_dly_shift    = '0;
    w_dly_shift[0] = w_next_bit;
    for (int unsigned i = 1; i <= LAT_BITS; i++) begin
      w_dly_shift[i] = r_dly[i-1];
    end
    w_dly_load    = '0;
    w_dly_load[0] = SeedEff[LFSR_W-1];
  end

  always_ff @(posedge i_tx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_cyc      <= '0;
      r_win      <= '0;
      r_edge_cnt <= '0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_dly      <= '0;
      r_tx_data  <= 1'b0;
      r_bit_stb  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_sync1 <= i_fsk_out;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      unique case (r_state)
        StIdle, StDone: begin
          r_bit_stb <= 1'b0;
          if (w_start_ok) begin
            r_state    <= StRun;
            r_cyc      <= '0;
            r_win      <= '0;
            r_edge_cnt <= '0;
            r_err_cnt  <= '0;
            r_dly      <= w_dly_load;
            r_tx_data  <= SeedEff[LFSR_W-1];
            r_bit_stb  <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
          end
        end
        StRun, StDrain: begin
          r_err_cnt <= w_err_next;
          if (w_win_end) begin
            r_cyc      <= '0;
            r_edge_cnt <= '0;
            r_win      <= r_win + 1'b1;
            r_dly      <= w_dly_shift;
            if (w_last_win) begin
              r_state   <= StDone;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (w_err_next == '0);
              r_tx_data <= 1'b0;
              r_bit_stb <= 1'b0;
            end else if ((r_state == StRun) && w_last_bit) begin
              r_state   <= StDrain;
              r_tx_data <= 1'b0;
              r_bit_stb <= 1'b0;
            end else if (r_state == StRun) begin
              r_tx_data <= w_lfsr_msb;
              r_bit_stb <= 1'b1;
            end else begin
              r_bit_stb <= 1'b0;
            end
          end else begin
            r_cyc      <= r_cyc + 1'b1;
            r_edge_cnt <= w_edge_total;
            r_bit_stb  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_bit_stb = r_bit_stb;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err_cnt;

endmodule
